calc_result_bcd: RTL and testbench

//  Downstream stage of the 8-bit add/sub datapath. Captures the raw sum/difference,

---
 rtl/calc_result_bcd_pkg.sv | 13 +
 rtl/calc_result_bcd_if.sv | 33 +++
 rtl/calc_result_bcd_digit_adj.sv | 10 +
 rtl/calc_result_bcd.sv | 120 ++++++++++++
 tb/tb_calc_result_bcd.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/calc_result_bcd_pkg.sv
// Shared constants for the add/sub result-to-BCD stage: default widths,
// iteration count and FSM state encoding.
package calc_result_bcd_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DIGITS_DEF = 3;
    localparam int ITER_DEF   = WIDTH_DEF + 1;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] S_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] S_CONV = 1'b1;

endpackage

// File: rtl/calc_result_bcd_if.sv
// Handshake and data bundle between the adder stage (master) and the
// result-to-BCD converter (slave).
interface calc_result_bcd_if
    import calc_result_bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) ();

    logic                  start;
    logic [WIDTH-1:0]      result;
    logic                  carry_out;
    logic                  sub;
    logic                  signed_md;
    logic                  a_msb;
    logic                  b_msb;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  ovf;

    modport master (
        output start, result, carry_out, sub, signed_md, a_msb, b_msb,
        input  busy, done, bcd, neg, ovf
    );

    modport slave (
        input  start, result, carry_out, sub, signed_md, a_msb, b_msb,
        output busy, done, bcd, neg, ovf
    );

endinterface

// File: rtl/calc_result_bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more so
// the following left shift carries correctly into the next decade.
module calc_result_bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/calc_result_bcd.sv
// Captures the adder's raw result, forms sign + magnitude and converts the
// magnitude to BCD with a one-bit-per-clock shift-add-3 loop.
module calc_result_bcd
    import calc_result_bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    calc_result_bcd_if.slave  bus
);

    localparam int ITER  = WIDTH + 1;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int BCD_W = 4 * DIGITS;

    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     mag_sr;
    logic [BCD_W-1:0]   dig_sr;
    logic [BCD_W-1:0]   dig_adj;
    logic [BCD_W-1:0]   dig_next;
    logic               neg_sh;
    logic               ovf_sh;
    logic [BCD_W-1:0]   bcd_q;
    logic               neg_q;
    logic               ovf_q;
    logic               done_q;
    logic               last_iter;

    logic [WIDTH-1:0]   res_neg;
    logic [WIDTH:0]     cap_mag;
    logic               cap_neg;
    logic               cap_ovf;

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        res_neg = -bus.result;
        cap_mag = {1'b0, bus.result};
        cap_neg = 1'b0;
        cap_ovf = 1'b0;
        if (bus.signed_md) begin
            // Two's complement: carry_out carries no magnitude information.
            cap_neg = bus.result[WIDTH-1];
            if (cap_neg) begin
                cap_mag = {1'b0, res_neg};
            end
            cap_ovf = (bus.a_msb == (bus.b_msb ^ bus.sub)) &&
                      (bus.result[WIDTH-1] != bus.a_msb);
        end else if (!bus.sub) begin
            cap_mag = {bus.carry_out, bus.result};
        end else if (!bus.carry_out) begin
            // Borrow out of an unsigned subtract: the true result is negative.
            cap_mag = {1'b0, res_neg};
            cap_neg = 1'b1;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        calc_result_bcd_digit_adj u_adj (
            .din  (dig_sr[4*g +: 4]),
            .dout (dig_adj[4*g +: 4])
        );
    end

    assign dig_next  = {dig_adj[BCD_W-2:0], mag_sr[WIDTH]};
    assign last_iter = (cnt == CNT_W'(ITER - 1));

    // NOTE: all state uses non-blocking assignments so every register in this
    // block samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mag_sr <= '0;
            dig_sr <= '0;
            neg_sh <= 1'b0;
            ovf_sh <= 1'b0;
            bcd_q  <= '0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mag_sr <= cap_mag;
                        dig_sr <= '0;
                        cnt    <= '0;
                        neg_sh <= cap_neg;
                        ovf_sh <= cap_ovf;
                        state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    dig_sr <= dig_next;
                    mag_sr <= {mag_sr[WIDTH-1:0], 1'b0};
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        bcd_q  <= dig_next;
                        neg_q  <= neg_sh;
                        ovf_q  <= ovf_sh;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (state == S_CONV);
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_calc_result_bcd.sv
// Scoreboard bench for calc_result_bcd: directed vectors push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_calc_result_bcd;

    localparam int LAT = 9;

    typedef struct {
        logic [11:0] bcd;
        logic        neg;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  result;
        logic        carry_out;
        logic        sub;
        logic        signed_md;
        logic        a_msb;
        logic        b_msb;
        logic [11:0] bcd;
        logic        neg;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    calc_result_bcd_if #(.WIDTH(8), .DIGITS(3)) bus ();

    calc_result_bcd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue(input vec_t v, input bit expect_done);
        bus.result    = v.result;
        bus.carry_out = v.carry_out;
        bus.sub       = v.sub;
        bus.signed_md = v.signed_md;
        bus.a_msb     = v.a_msb;
        bus.b_msb     = v.b_msb;
        bus.start     = 1'b1;
        if (expect_done) sb.push_back('{v.bcd, v.neg, v.ovf, cyc + 1 + LAT});
        @(negedge clk);
        bus.start     = 1'b0;
        bus.result    = ~v.result;
        bus.carry_out = ~v.carry_out;
        bus.sub       = ~v.sub;
        bus.signed_md = ~v.signed_md;
        bus.a_msb     = ~v.a_msb;
        bus.b_msb     = ~v.b_msb;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("bcd", {20'd0, bus.bcd}, {20'd0, e.bcd});
                check("neg", {31'd0, bus.neg}, {31'd0, e.neg});
                check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
                check("latency", cyc, e.done_cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // result, carry_out, sub, signed_md, a_msb, b_msb -> bcd, neg, ovf
        vec_t vecs[8];
        vec_t glitch;
        vecs[0] = '{8'h2C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h300, 1'b0, 1'b0}; // 200+100
        vecs[1] = '{8'hFB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h005, 1'b1, 1'b0}; // 5-10
        vecs[2] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h128, 1'b1, 1'b0}; // -128+0
        vecs[3] = '{8'hC8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h056, 1'b1, 1'b1}; // 100+100 signed
        vecs[4] = '{8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h510, 1'b0, 1'b0}; // 255+255
        vecs[5] = '{8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h005, 1'b0, 1'b0}; // 10-5
        vecs[6] = '{8'h38, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h056, 1'b0, 1'b1}; // -100-100 signed
        vecs[7] = '{8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h005, 1'b0, 1'b0}; // signed, carry ignored

        rst = 1'b1;
        bus.start = 1'b0;
        bus.result = '0;
        bus.carry_out = 1'b0;
        bus.sub = 1'b0;
        bus.signed_md = 1'b0;
        bus.a_msb = 1'b0;
        bus.b_msb = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_bcd",  {20'd0, bus.bcd},  0);
        check("rst_neg",  {31'd0, bus.neg},  0);
        check("rst_ovf",  {31'd0, bus.ovf},  0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i], 1'b1);
            if (i == 0) check("busy_after_start", {31'd0, bus.busy}, 1);
            repeat (10) @(negedge clk);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        issue('{8'h7B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b0, 1'b0}, 1'b1);
        repeat (2) @(negedge clk);
        glitch = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h511, 1'b0, 1'b0};
        issue(glitch, 1'b0);
        repeat (6) @(negedge clk);
        check("done_cycle_pulse", {31'd0, bus.done}, 1);
        issue('{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0}, 1'b1);
        repeat (10) @(negedge clk);

        // Reset at iteration 4 aborts the conversion with no done pulse.
        issue('{8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h153, 1'b0, 1'b0}, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 0);
        check("abort_bcd",  {20'd0, bus.bcd},  0);
        check("abort_done", {31'd0, bus.done}, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue('{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h255, 1'b0, 1'b0}, 1'b1);

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
